ifu_fetch_ctrl: RTL and testbench

//  Holds the architectural PC and fetches instructions from instruction memory.

---
 rtl/ifu_fetch_ctrl.sv | 170 +++++++++++++++++
 tb/tb_ifu_fetch_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_ctrl.sv
// ============================================================================
// Module   : ifu_fetch_ctrl
// Purpose  : Holds the architectural PC and runs one instruction fetch at a
//            time (request, response, hand-off to decode, wait for next PC).
//            Optional macro PC_MISALIGN_CHK_EN adds a pc[1] misalignment check
//            and the inst_misalign port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_fetch_ctrl #(
    parameter int              XLEN     = 64,
    parameter int              ILEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            npc_valid,
    input  logic [XLEN-1:0] npc,
    input  logic            flush,
    input  logic [XLEN-1:0] flush_pc,
`ifdef PC_MISALIGN_CHK_EN
    output logic            inst_misalign,
`endif
    output logic [XLEN-1:0] pc
);

    typedef enum logic [2:0] {
        S_BOOT  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_NPC   = 3'd4,
        S_DRAIN = 3'd5
    } state_t;

    localparam logic [XLEN-1:0] c_pc_mask = {{(XLEN-1){1'b1}}, 1'b0};

    state_t          r_state, w_state_nxt;
    logic [XLEN-1:0] r_pc, w_pc_nxt;
    logic [ILEN-1:0] r_inst, w_inst_nxt;
    logic [XLEN-1:0] r_inst_pc, w_inst_pc_nxt;
    logic            w_mis_skip;
    logic            w_req_fire;

`ifdef PC_MISALIGN_CHK_EN
    logic            r_misalign, w_misalign_nxt;
    assign w_mis_skip    = (r_state == S_REQ) && r_pc[1];
    assign inst_misalign = r_misalign;
`else
    assign w_mis_skip    = 1'b0;
`endif

    assign imem_req_valid = (r_state == S_REQ) && !w_mis_skip;
    assign imem_req_addr  = r_pc;
    assign inst_valid     = (r_state == S_HOLD);
    assign inst           = r_inst;
    assign inst_pc        = r_inst_pc;
    assign pc             = r_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_inst_nxt    = r_inst;
        w_inst_pc_nxt = r_inst_pc;
`ifdef PC_MISALIGN_CHK_EN
        w_misalign_nxt = r_misalign;
`endif
        case (r_state)
            S_BOOT: w_state_nxt = S_REQ;
            S_REQ: begin
                if (w_mis_skip) begin
                    w_state_nxt   = S_HOLD;
                    w_inst_nxt    = '0;
                    w_inst_pc_nxt = r_pc;
`ifdef PC_MISALIGN_CHK_EN
                    w_misalign_nxt = 1'b1;
`endif
                end else if (w_req_fire) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    w_state_nxt   = S_HOLD;
                    w_inst_nxt    = imem_rsp_data;
                    w_inst_pc_nxt = r_pc;
`ifdef PC_MISALIGN_CHK_EN
                    w_misalign_nxt = 1'b0;
`endif
                end
            end
            S_HOLD: begin
                if (inst_ready) begin
                    if (npc_valid) begin
                        w_pc_nxt    = npc & c_pc_mask;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_state_nxt = S_NPC;
                    end
                end
            end
            S_NPC: begin
                if (npc_valid) begin
                    w_pc_nxt    = npc & c_pc_mask;
                    w_state_nxt = S_REQ;
                end
            end
            S_DRAIN: begin
                if (imem_rsp_valid) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_BOOT;
        endcase

        // A redirect wins over everything; DRAIN only if a response is still owed.
        if (flush && (r_state != S_BOOT)) begin
            w_pc_nxt      = flush_pc & c_pc_mask;
            w_inst_nxt    = r_inst;
            w_inst_pc_nxt = r_inst_pc;
`ifdef PC_MISALIGN_CHK_EN
            w_misalign_nxt = r_misalign;
`endif
            if (w_req_fire ||
                (((r_state == S_WAIT) || (r_state == S_DRAIN)) && !imem_rsp_valid)) begin
                w_state_nxt = S_DRAIN;
            end else begin
                w_state_nxt = S_REQ;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_BOOT;
            r_pc      <= RESET_PC;
            r_inst    <= '0;
            r_inst_pc <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_inst    <= w_inst_nxt;
            r_inst_pc <= w_inst_pc_nxt;
        end
    end

`ifdef PC_MISALIGN_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_misalign_nxt;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ifu_fetch_ctrl.sv
// ============================================================================
// Module   : tb_ifu_fetch_ctrl
// Purpose  : Self-checking bench for ifu_fetch_ctrl: directed scenarios plus
//            randomized traffic against a flag-based fetch reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifu_fetch_ctrl;

    localparam int          XLEN     = 64;
    localparam int          ILEN     = 32;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            imem_req_valid, imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;
    logic            inst_valid, inst_ready;
    logic [ILEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            npc_valid;
    logic [XLEN-1:0] npc;
    logic            flush;
    logic [XLEN-1:0] flush_pc;
    logic [XLEN-1:0] pc;
`ifdef PC_MISALIGN_CHK_EN
    logic            inst_misalign;
`endif

    ifu_fetch_ctrl #(.XLEN(XLEN), .ILEN(ILEN), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .npc_valid      (npc_valid),
        .npc            (npc),
        .flush          (flush),
        .flush_pc       (flush_pc),
`ifdef PC_MISALIGN_CHK_EN
        .inst_misalign  (inst_misalign),
`endif
        .pc             (pc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    // Reference model: a fetch is "wanted", "owed" by imem, possibly "stale",
    // an instruction may be "held" for decode, or we may be "waiting for npc".
    bit          m_boot, m_want, m_owed, m_stale, m_held, m_wait_npc, m_mis;
    logic [63:0] m_pc, m_ipc;
    logic [31:0] m_inst;

    // imem model: one outstanding request at most.
    bit b_owed, b_acc;

    task automatic model_reset();
        m_boot = 1; m_want = 0; m_owed = 0; m_stale = 0; m_held = 0;
        m_wait_npc = 0; m_mis = 0; m_pc = RESET_PC; m_ipc = '0; m_inst = '0;
    endtask

    function automatic bit model_req();
        bit r;
        r = !m_boot && m_want && !m_owed;
`ifdef PC_MISALIGN_CHK_EN
        r = r && !m_pc[1];
`endif
        return r;
    endfunction

    task automatic check_outputs();
        check_val("req_valid", imem_req_valid, model_req());
        check_val("req_addr",  imem_req_addr,  m_pc);
        check_val("pc",        pc,             m_pc);
        check_val("inst_valid", inst_valid,    m_held);
        check_val("inst",      inst,           m_inst);
        check_val("inst_pc",   inst_pc,        m_ipc);
`ifdef PC_MISALIGN_CHK_EN
        check_val("misalign",  inst_misalign,  m_mis);
`endif
    endtask

    task automatic model_step();
        bit n_want, n_owed, n_stale, n_held, n_wait, n_mis;
        logic [63:0] n_pc, n_ipc;
        logic [31:0] n_inst;
        if (m_boot) begin
            m_boot = 0;
            m_want = 1;
            return;
        end
        n_want = m_want; n_owed = m_owed; n_stale = m_stale; n_held = m_held;
        n_wait = m_wait_npc; n_mis = m_mis; n_pc = m_pc; n_ipc = m_ipc; n_inst = m_inst;
        if (model_req() && imem_req_ready) begin
            n_want = 0;
            n_owed = 1;
        end
        if (m_owed && imem_rsp_valid) begin
            n_owed = 0;
            n_stale = 0;
            if (!m_stale && !flush) begin
                n_held = 1; n_inst = imem_rsp_data; n_ipc = m_pc; n_mis = 0;
            end
        end
`ifdef PC_MISALIGN_CHK_EN
        if (m_want && !m_owed && m_pc[1] && !flush) begin
            n_want = 0; n_held = 1; n_inst = '0; n_ipc = m_pc; n_mis = 1;
        end
`endif
        if (!flush && m_held && inst_ready) begin
            n_held = 0;
            if (npc_valid) begin
                n_pc = {npc[63:1], 1'b0};
                n_want = 1;
            end else begin
                n_wait = 1;
            end
        end
        if (!flush && m_wait_npc && npc_valid) begin
            n_wait = 0;
            n_pc = {npc[63:1], 1'b0};
            n_want = 1;
        end
        if (flush) begin
            n_pc = {flush_pc[63:1], 1'b0};
            n_held = 0; n_wait = 0; n_want = 1;
            n_stale = n_owed;
        end
        m_want = n_want; m_owed = n_owed; m_stale = n_stale; m_held = n_held;
        m_wait_npc = n_wait; m_mis = n_mis; m_pc = n_pc; m_ipc = n_ipc; m_inst = n_inst;
    endtask

    task automatic drive(input bit rdy, input bit rsp, input logic [31:0] data,
                         input bit ir, input bit nv, input logic [63:0] np,
                         input bit fl, input logic [63:0] fpc);
        imem_req_ready = rdy; imem_rsp_valid = rsp; imem_rsp_data = data;
        inst_ready = ir; npc_valid = nv; npc = np; flush = fl; flush_pc = fpc;
        #1;
        b_acc = imem_req_valid && imem_req_ready;
    endtask

    task automatic drive_random();
        bit rdy, rsp, fl;
        rdy = b_owed ? 1'b0 : ($urandom_range(0, 3) != 0);
        rsp = b_owed && ($urandom_range(0, 2) == 0);
        fl  = ($urandom_range(0, 15) == 0) && !(rsp && m_owed && !m_stale);
        drive(rdy, rsp, $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              RESET_PC + 64'($urandom_range(0, 4095)), fl,
              RESET_PC + 64'($urandom_range(0, 65535)));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        if (imem_rsp_valid) b_owed = 0;
        if (b_acc) b_owed = 1;
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        rst_n = 1'b0;
        b_owed = 0; b_acc = 0;
        model_reset();
        drive(0, 0, '0, 0, 0, '0, 0, '0);
        repeat (2) @(negedge clk);
        check_val("rst_req_valid", imem_req_valid, 0);
        check_val("rst_inst_valid", inst_valid, 0);
        check_val("rst_pc", pc, 64'h8000_0000);
        check_val("rst_inst", inst, 0);
        check_val("rst_inst_pc", inst_pc, 0);
`ifdef PC_MISALIGN_CHK_EN
        check_val("rst_misalign", inst_misalign, 0);
`endif
        rst_n = 1'b1;

        // T1: first fetch after reset
        drive(1, 0, '0, 0, 0, '0, 0, '0);
        tick();
        check_val("t1_req_valid", imem_req_valid, 1);
        check_val("t1_req_addr", imem_req_addr, 64'h8000_0000);
        tick();
        drive(0, 1, 32'h0000_0013, 0, 0, '0, 0, '0);
        tick();
        check_val("t1_inst_valid", inst_valid, 1);
        check_val("t1_inst", inst, 32'h13);
        check_val("t1_inst_pc", inst_pc, 64'h8000_0000);

        // T2: hand-off and next PC in the same cycle
        drive(0, 0, '0, 1, 1, 64'h8000_0005, 0, '0);
        tick();
        check_val("t2_req_valid", imem_req_valid, 1);
        check_val("t2_req_addr", imem_req_addr, 64'h8000_0004);

        // T3: imem back-pressure
        drive(0, 0, '0, 0, 0, '0, 0, '0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("t3_req_valid", imem_req_valid, 1);
            check_val("t3_req_addr", imem_req_addr, 64'h8000_0004);
            check_val("t3_inst_valid", inst_valid, 0);
        end

        // T4: flush while waiting; the stale response must be dropped
        drive(1, 0, '0, 0, 0, '0, 0, '0);
        tick();
        drive(0, 0, '0, 0, 0, '0, 1, 64'h8000_1000);
        tick();
        check_val("t4_drain_req", imem_req_valid, 0);
        drive(0, 1, 32'hDEAD_BEEF, 0, 0, '0, 0, '0);
        tick();
        check_val("t4_req_addr", imem_req_addr, 64'h8000_1000);
        check_val("t4_no_stale", inst_valid, 0);
        drive(1, 0, '0, 0, 0, '0, 0, '0);
        tick();
        drive(0, 1, 32'h0010_0093, 0, 0, '0, 0, '0);
        tick();
        check_val("t4_inst", inst, 32'h0010_0093);
        check_val("t4_inst_pc", inst_pc, 64'h8000_1000);

        // T5: flush beats npc_valid and inst_ready in HOLD
        drive(0, 0, '0, 1, 1, 64'h8000_0010, 1, 64'h8000_0200);
        tick();
        check_val("t5_pc", pc, 64'h8000_0200);
        check_val("t5_inst_valid", inst_valid, 0);

        // Flush while draining, then flush together with the stale response
        drive(1, 0, '0, 0, 0, '0, 0, '0);
        tick();
        drive(0, 0, '0, 0, 0, '0, 1, 64'h8000_0301);
        tick();
        drive(0, 0, '0, 0, 0, '0, 1, 64'h8000_0300);
        tick();
        check_val("drain_stay", imem_req_valid, 0);
        check_val("drain_pc", pc, 64'h8000_0300);
        drive(0, 1, 32'hBAD0_BAD0, 0, 0, '0, 1, 64'h8000_0401);
        tick();
        check_val("drain_exit_req", imem_req_valid, 1);
        check_val("drain_exit_pc", pc, 64'h8000_0400);

        // T6: npc with pc[1] set
        drive(1, 0, '0, 0, 0, '0, 0, '0);
        tick();
        drive(0, 1, 32'h0000_0073, 0, 0, '0, 0, '0);
        tick();
        drive(0, 0, '0, 1, 1, 64'h8000_0006, 0, '0);
        tick();
        check_val("t6_pc", pc, 64'h8000_0006);
`ifdef PC_MISALIGN_CHK_EN
        check_val("t6_no_req", imem_req_valid, 0);
        drive(1, 0, '0, 0, 0, '0, 0, '0);
        tick();
        check_val("t6_inst_valid", inst_valid, 1);
        check_val("t6_inst", inst, 0);
        check_val("t6_inst_pc", inst_pc, 64'h8000_0006);
        check_val("t6_misalign", inst_misalign, 1);
`else
        check_val("t6_req_valid", imem_req_valid, 1);
        check_val("t6_req_addr", imem_req_addr, 64'h8000_0006);
`endif

        // Randomized traffic with one asynchronous reset in the middle
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1500) begin
                #2 rst_n = 1'b0;
                #1;
                model_reset();
                b_acc = 0;
                check_outputs();
                @(posedge clk);
                if (imem_rsp_valid) b_owed = 0;
                @(negedge clk);
                check_outputs();
                rst_n = 1'b1;
            end
            drive_random();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
